cnt_cmd_arbiter: RTL and testbench
==================================

// Module: cnt_cmd_arbiter
// PURPOSE
//  Shares one up/down counter (WIDTH-bit; active-low load, up/down select, count enable) among NREQ requesters.
//  Each requester issues LOAD/INC/DEC/READ commands over a valid/ready handshake; round-robin grant.
//  Drives the counter control pins, then returns the resulting count with the requester ID.
//  Sits between client FSMs and the counter instance. Only this block touches the counter controls.
// PARAMETERS
//  WIDTH  16  counter/data width
//  NREQ   2   number of requesters (2..8)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  req_valid  in   NREQ        per-requester command valid
//  req_op     in   2*NREQ      per-requester op: 00 READ, 01 LOAD, 10 INC, 11 DEC
//  req_data   in   WIDTH*NREQ  per-requester load value (LOAD only)
//  req_ready  out  NREQ        one-hot accept pulse; command taken when valid&&ready
//  rsp_valid  out  1           response valid; held until rsp_ready
//  rsp_ready  in   1           response consumer ready
//  rsp_id     out  $clog2(NREQ) granted requester index
//  rsp_data   out  WIDTH       counter value after the command
//  rsp_sat    out  1           command suppressed by saturation (0 unless CNT_ARB_SATURATE_EN)
//  ld_cnt     out  1           to counter; active-low load
//  updn_cnt   out  1           to counter; 1=up, 0=down
//  count_enb  out  1           to counter; count enable
//  cnt_din    out  WIDTH       to counter data_in
//  cnt_dout   in   WIDTH       from counter data_out
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_sat=0, ld_cnt=1, updn_cnt=0,
//   count_enb=0, cnt_din=0, state=IDLE, rr pointer=0. Counter controls at idle values = hold.
//  FSM: IDLE -> ISSUE -> CAPT -> RSP -> IDLE; one command in flight, no new grant until RSP completes.
//  IDLE: if any req_valid, grant first valid index at or after rr pointer (wrapping); pulse req_ready
//   for that requester one cycle; latch op/data/id; rr pointer <= grant+1 mod NREQ; -> ISSUE.
//  ISSUE (1 cycle, registered outputs): LOAD: ld_cnt=0, cnt_din=data. INC: ld_cnt=1, count_enb=1,
//   updn_cnt=1. DEC: ld_cnt=1, count_enb=1, updn_cnt=0. READ: idle values. -> CAPT.
//  CAPT: controls back to idle values; capture cnt_dout into rsp_data; -> RSP.
//  RSP: rsp_valid=1 with stable rsp_id/rsp_data/rsp_sat; on rsp_ready -> IDLE, rsp_valid=0 next cycle.
//  Latency: accept edge to rsp_valid = 3 cycles; back-to-back throughput 1 command / 4 cycles.
//  Counter wraps modulo 2**WIDTH (FFFF+1=0, 0-1=FFFF) unless saturation compiled in.
//  Requester holds valid/op/data stable until ready; withdrawing valid before grant is allowed.
//  rsp_ready held low stalls in RSP indefinitely; pending requests wait, not lost.
//  rst mid-command: immediate return to IDLE, controls to idle values, response dropped; counter not reset.
// CONFIGURATION
//  CNT_ARB_SATURATE_EN defined: in ISSUE, INC with cnt_dout=all-ones or DEC with cnt_dout=0 keeps
//   count_enb=0 and sets rsp_sat=1; rsp_data returns the unchanged value.
//  Not defined: no check, natural wrap, rsp_sat tied 0.
// STRUCTURE
//  Package cnt_arb_pkg: cnt_op_e (READ/LOAD/INC/DEC, 2-bit), arb_state_e (IDLE/ISSUE/CAPT/RSP),
//   idle-control constants (LD_IDLE=1, ENB_IDLE=0).
//  Sub-module rr_arbiter #(NREQ): req vector + pointer in -> one-hot grant, grant index.
// TESTING
//  Req0 LOAD 0x1234 alone -> req_ready[0] pulse, ld_cnt=0 one cycle, 3 cycles later rsp_data=0x1234, rsp_id=0.
//  Req0 INC, Req1 DEC both valid from reset -> req0 served first, then req1; rsp 0x1235 then 0x1234.
//  Both hold valid for 6 commands -> grants alternate 0,1,0,1,0,1; no starvation.
//  LOAD 0xFFFF then INC -> rsp_data=0x0000 (wrap); with CNT_ARB_SATURATE_EN rsp_data=0xFFFF, rsp_sat=1.
//  rsp_ready low 10 cycles in RSP -> rsp_valid/data stable, no req_ready pulses; release -> next grant.
//  rst asserted during ISSUE -> outputs at reset values same cycle; new LOAD after release completes normally.

Source files
------------

// File: rtl/cnt_arb_pkg.sv
// Shared types and idle control levels for the counter command arbiter.
package cnt_arb_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_DEC  = 2'b11
  } cnt_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    CAPT  = 2'b10,
    RSP   = 2'b11
  } arb_state_e;

  // Counter pin levels that make the external counter hold its value.
  localparam logic LD_IDLE   = 1'b1;
  localparam logic ENB_IDLE  = 1'b0;
  localparam logic UPDN_IDLE = 1'b0;

endpackage

// File: rtl/cnt_cmd_arbiter_rr.sv
// Round-robin pick: first asserted request at or after ptr_i, wrapping; purely combinational.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] gnt_idx_o,
  output logic                    any_o
);

  localparam int IW = $clog2(NREQ);

  always_comb begin : pick
    int idx;
    idx       = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/cnt_cmd_arbiter.sv
// Shares one up/down counter among NREQ requesters: grant, drive pins, capture, respond (4 cycles/command).
// Optional CNT_ARB_SATURATE_EN suppresses INC at all-ones and DEC at zero, flagging rsp_sat.
module cnt_cmd_arbiter
  import cnt_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_sat,
  output logic                    ld_cnt,
  output logic                    updn_cnt,
  output logic                    count_enb,
  output logic [WIDTH-1:0]        cnt_din,
  input  logic [WIDTH-1:0]        cnt_dout
);

  localparam int IW = $clog2(NREQ);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_sat_q, rsp_sat_d;
  logic              ld_q, ld_d, updn_q, updn_d, enb_q, enb_d;
  logic [WIDTH-1:0]  din_q, din_d;

  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  cnt_op_e           gnt_op;
  logic [WIDTH-1:0]  gnt_data;
  logic              sat_hit;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  assign gnt_op   = cnt_op_e'(req_op[int'(gnt_idx)*2 +: 2]);
  assign gnt_data = req_data[int'(gnt_idx)*WIDTH +: WIDTH];

  // Nothing else moves the counter, so its value at grant time is the value ISSUE will act on.
`ifdef CNT_ARB_SATURATE_EN
  assign sat_hit = ((gnt_op == OP_INC) && (cnt_dout == '1)) ||
                   ((gnt_op == OP_DEC) && (cnt_dout == '0));
`else
  assign sat_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_sat_d  = rsp_sat_q;
    ld_d       = LD_IDLE;
    enb_d      = ENB_IDLE;
    updn_d     = UPDN_IDLE;
    din_d      = '0;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any && !rst) begin
          req_ready = gnt;
          rsp_id_d  = gnt_idx;
          rsp_sat_d = sat_hit;
          ptr_d     = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
          state_d   = ISSUE;
          case (gnt_op)
            OP_LOAD: begin
              ld_d  = 1'b0;
              din_d = gnt_data;
            end
            OP_INC: begin
              enb_d  = !sat_hit;
              updn_d = 1'b1;
            end
            OP_DEC:  enb_d = !sat_hit;
            default: ;
          endcase
        end
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        rsp_data_d = cnt_dout;
        state_d    = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_sat_q  <= 1'b0;
      ld_q       <= LD_IDLE;
      updn_q     <= UPDN_IDLE;
      enb_q      <= ENB_IDLE;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_sat_q  <= rsp_sat_d;
      ld_q       <= ld_d;
      updn_q     <= updn_d;
      enb_q      <= enb_d;
      din_q      <= din_d;
    end
  end

  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_sat   = rsp_sat_q;
  assign ld_cnt    = ld_q;
  assign updn_cnt  = updn_q;
  assign count_enb = enb_q;
  assign cnt_din   = din_q;

endmodule

// File: tb/tb_cnt_cmd_arbiter.sv
// Bench for cnt_cmd_arbiter with a behavioural up/down counter and a response scoreboard.
module tb_cnt_cmd_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 2;

`ifdef CNT_ARB_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  typedef struct packed {logic [1:0] op; logic [15:0] data;} cmd_t;
  typedef struct packed {logic id; logic [15:0] data; logic sat;} rsp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid, rsp_ready;
  logic [0:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_sat, ld_cnt, updn_cnt, count_enb;
  logic [WIDTH-1:0]      cnt_din, cnt_dout;
  logic [WIDTH-1:0]      cnt = 16'h0000;

  cmd_t q0[$];
  cmd_t q1[$];
  rsp_t exp_q[$];
  rsp_t e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cnt_cmd_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_sat(rsp_sat), .ld_cnt(ld_cnt), .updn_cnt(updn_cnt),
    .count_enb(count_enb), .cnt_din(cnt_din), .cnt_dout(cnt_dout)
  );

  // External counter: not reset by rst, only driven through the arbiter's pins.
  always @(posedge clk) begin
    if (!ld_cnt)        cnt <= cnt_din;
    else if (count_enb) cnt <= updn_cnt ? cnt + 16'd1 : cnt - 16'd1;
  end
  assign cnt_dout = cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got id=%0d data=%h with nothing expected", rsp_id, rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_sat", 32'(rsp_sat), 32'(e.sat));
      end
    end
  end

  function automatic cmd_t mk(input logic [1:0] op, input logic [15:0] d);
    cmd_t c;
    c.op = op;
    c.data = d;
    return c;
  endfunction

  function automatic rsp_t mr(input logic id, input logic [15:0] d, input logic s);
    rsp_t r;
    r.id = id;
    r.data = d;
    r.sat = s;
    return r;
  endfunction

  // Presents queued commands per requester, pops on accept, until all responses are seen.
  task automatic run_cmds();
    logic [NREQ-1:0] acc;
    int cyc = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && cyc < 400) begin
      req_valid = {q1.size() != 0, q0.size() != 0};
      if (q0.size() != 0) begin req_op[1:0] = q0[0].op; req_data[15:0]  = q0[0].data; end
      if (q1.size() != 0) begin req_op[3:2] = q1[0].op; req_data[31:16] = q1[0].data; end
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      if (acc[0]) void'(q0.pop_front());
      if (acc[1]) void'(q1.pop_front());
      cyc++;
    end
    req_valid = '0;
    if (cyc >= 400) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got %0d pending responses expected 0", exp_q.size());
      q0.delete(); q1.delete(); exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic stall_chk();
    int n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL stall_wait: got rsp_valid=0 expected 1");
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", 32'(rsp_data), 32'h0042);
      check("stall_id", 32'(rsp_id), 32'd0);
      check("stall_no_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_data = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_sat", 32'(rsp_sat), 32'd0);
    check("rst_ld_cnt", 32'(ld_cnt), 32'd1);
    check("rst_updn", 32'(updn_cnt), 32'd0);
    check("rst_enb", 32'(count_enb), 32'd0);
    check("rst_din", 32'(cnt_din), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single LOAD with cycle-by-cycle pin checks
    exp_q.push_back(mr(1'b0, 16'h1234, 1'b0));
    req_valid = 2'b01; req_op[1:0] = 2'b01; req_data[15:0] = 16'h1234;
    @(negedge clk);
    check("load_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("issue_ld_low", 32'(ld_cnt), 32'd0);
    check("issue_din", 32'(cnt_din), 32'h1234);
    @(negedge clk);
    check("capt_ld_high", 32'(ld_cnt), 32'd1);
    check("capt_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rsp_latency", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;

    // Simultaneous INC/DEC from reset pointer; counter keeps 0x1234 across reset
    pulse_reset();
    q0.push_back(mk(2'b10, 16'h0)); q1.push_back(mk(2'b11, 16'h0));
    exp_q.push_back(mr(1'b0, 16'h1235, 1'b0));
    exp_q.push_back(mr(1'b1, 16'h1234, 1'b0));
    run_cmds();

    // Six back-to-back commands alternate 0,1,0,1,0,1
    q0.push_back(mk(2'b10, 16'h0)); q0.push_back(mk(2'b10, 16'h0)); q0.push_back(mk(2'b10, 16'h0));
    q1.push_back(mk(2'b00, 16'h0)); q1.push_back(mk(2'b01, 16'h0100)); q1.push_back(mk(2'b11, 16'h0));
    exp_q.push_back(mr(1'b0, 16'h1235, 1'b0));
    exp_q.push_back(mr(1'b1, 16'h1235, 1'b0));
    exp_q.push_back(mr(1'b0, 16'h1236, 1'b0));
    exp_q.push_back(mr(1'b1, 16'h0100, 1'b0));
    exp_q.push_back(mr(1'b0, 16'h0101, 1'b0));
    exp_q.push_back(mr(1'b1, 16'h0100, 1'b0));
    run_cmds();

    // Wrap / saturation at both ends
    q0.push_back(mk(2'b01, 16'hFFFF)); q0.push_back(mk(2'b10, 16'h0));
    exp_q.push_back(mr(1'b0, 16'hFFFF, 1'b0));
    exp_q.push_back(mr(1'b0, SAT ? 16'hFFFF : 16'h0000, SAT));
    run_cmds();
    q1.push_back(mk(2'b01, 16'h0000)); q1.push_back(mk(2'b11, 16'h0));
    exp_q.push_back(mr(1'b1, 16'h0000, 1'b0));
    exp_q.push_back(mr(1'b1, SAT ? 16'h0000 : 16'hFFFF, SAT));
    run_cmds();

    // Response backpressure: RSP held 10 cycles, req1 waits
    rsp_ready = 1'b0;
    q0.push_back(mk(2'b01, 16'h0042)); q1.push_back(mk(2'b10, 16'h0));
    exp_q.push_back(mr(1'b0, 16'h0042, 1'b0));
    exp_q.push_back(mr(1'b1, 16'h0043, 1'b0));
    fork
      run_cmds();
      stall_chk();
    join

    // Reset during ISSUE drops the LOAD; later commands complete normally
    req_valid = 2'b01; req_op[1:0] = 2'b01; req_data[15:0] = 16'h5555;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = '0;
    rst = 1'b1;
    #1;
    check("abort_ld", 32'(ld_cnt), 32'd1);
    check("abort_din", 32'(cnt_din), 32'd0);
    check("abort_enb", 32'(count_enb), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    q1.push_back(mk(2'b01, 16'h0777));
    exp_q.push_back(mr(1'b1, 16'h0777, 1'b0));
    run_cmds();
    q0.push_back(mk(2'b00, 16'h0));
    exp_q.push_back(mr(1'b0, 16'h0777, 1'b0));
    run_cmds();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
